// File: rtl/multi_digit_access_ctrl.sv
// rtl/multi_digit_access_ctrl.sv - multi-digit password entry controller with attempt limit and lockout
module multi_digit_access_ctrl #(
    parameter int  DIGITS         = 4,
    parameter int  DIGIT_W        = 4,
    parameter int  MAX_ATTEMPTS   = 3,
    parameter int  BLINK_CYCLES   = 8,
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int AW = $clog2(MAX_ATTEMPTS + 1),
    localparam int CW = $clog2(DIGITS + 1),
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1),
    localparam int BW = $clog2(BLINK_CYCLES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      userIDfoundFlag,
    input  logic                      loadButton_s,
    input  logic                      logoutButton_s,
    input  logic [DIGIT_W-1:0]        passInput,
    input  logic [DIGITS*DIGIT_W-1:0] PASSWORD,
    output logic                      accessFlag,
    output logic                      blinkFlag,
    output logic                      outOfAttemptsFlag,
    output logic [AW-1:0]             attemptsLeft,
    output logic [CW-1:0]             digitCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_VERIFY,
        S_GRANTED,
        S_DENIED,
        S_LOCKED
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      digit_cnt_q;
    logic               mismatch_q;
    logic [TW-1:0]      idle_cnt_q;
    logic [BW-1:0]      blink_cnt_q;
    logic [AW-1:0]      attempts_q;
    logic               access_q;
    logic               blink_q;
    logic               lock_q;

    logic [DIGIT_W-1:0] exp_digit;
    logic               mismatch_d;

    // Digit 0 sits in the MSBs; select the digit matching the current position.
    always_comb begin
        exp_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_cnt_q == CW'(i)) begin
                exp_digit = PASSWORD[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
        mismatch_d = mismatch_q | (passInput != exp_digit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            digit_cnt_q <= '0;
            mismatch_q  <= 1'b0;
            idle_cnt_q  <= '0;
            blink_cnt_q <= '0;
            attempts_q  <= AW'(MAX_ATTEMPTS);
            access_q    <= 1'b0;
            blink_q     <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    digit_cnt_q <= '0;
                    mismatch_q  <= 1'b0;
                    idle_cnt_q  <= '0;
                    if (userIDfoundFlag) state_q <= S_ENTRY;
                end
                S_ENTRY: begin
                    // Losing the user wins over a same-cycle load and costs no attempt.
                    if (!userIDfoundFlag) begin
                        state_q     <= S_IDLE;
                        digit_cnt_q <= '0;
                        mismatch_q  <= 1'b0;
                        idle_cnt_q  <= '0;
                    end else if (loadButton_s) begin
                        mismatch_q <= mismatch_d;
                        idle_cnt_q <= '0;
                        if (digit_cnt_q != CW'(DIGITS)) digit_cnt_q <= digit_cnt_q + CW'(1);
                        if (digit_cnt_q == CW'(DIGITS - 1)) state_q <= S_VERIFY;
                    end else if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        mismatch_q <= 1'b1;
                        state_q    <= S_VERIFY;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + TW'(1);
                    end
                end
                S_VERIFY: begin
                    if (!mismatch_q) begin
                        attempts_q <= AW'(MAX_ATTEMPTS);
                        access_q   <= 1'b1;
                        state_q    <= S_GRANTED;
                    end else begin
                        if (attempts_q != '0) attempts_q <= attempts_q - AW'(1);
                        if (attempts_q <= AW'(1)) begin
                            lock_q  <= 1'b1;
                            state_q <= S_LOCKED;
                        end else begin
                            blink_q     <= 1'b1;
                            blink_cnt_q <= '0;
                            state_q     <= S_DENIED;
                        end
                    end
                end
                S_GRANTED: begin
                    if (logoutButton_s || !userIDfoundFlag) begin
                        access_q    <= 1'b0;
                        digit_cnt_q <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                S_DENIED: begin
                    if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
                        blink_q     <= 1'b0;
                        digit_cnt_q <= '0;
                        state_q     <= S_IDLE;
                    end else begin
                        blink_cnt_q <= blink_cnt_q + BW'(1);
                    end
                end
                S_LOCKED: begin
                    state_q <= S_LOCKED;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign accessFlag        = access_q;
    assign blinkFlag         = blink_q;
    assign outOfAttemptsFlag = lock_q;
    assign attemptsLeft      = attempts_q;
    assign digitCount        = digit_cnt_q;

endmodule
